// File: rtl/fft_iter_addr_gen.sv
// In-place radix-2 DIT butterfly address generator: walks butterfly/layer counters and
// registers operand A/B addresses, twiddle index, layer number and protocol-error flag.
module fft_iter_addr_gen #(
   parameter int LAYERS      = 5,
   parameter int BUTTERFLYES = 16,
   parameter int LayWL       = 3,
   parameter int ButtWL      = 4,
   parameter int AddrWL      = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              ADDR_RST,
   input  logic              ADDR_EN,
   input  logic              LAY_EN,
   output logic [AddrWL-1:0] ADDR_A,
   output logic [AddrWL-1:0] ADDR_B,
   output logic [ButtWL-1:0] TW_ADDR,
   output logic [LayWL-1:0]  LAY_NUM,
   output logic              LAST_BUT,
   output logic              PROT_ERR
);

   localparam logic [ButtWL-1:0] B_LAST = ButtWL'(BUTTERFLYES - 1);
   localparam logic [LayWL-1:0]  S_LAST = LayWL'(LAYERS - 1);

   logic [ButtWL-1:0] b, b_nxt;
   logic [LayWL-1:0]  s, s_nxt;
   logic              err_set;
   logic [AddrWL-1:0] bw, span, p;
   logic [AddrWL-1:0] a_nxt, bb_nxt;
   logic [ButtWL-1:0] tw_nxt;

   always_comb begin
      b_nxt = b;
      s_nxt = s;
      if (ADDR_EN) begin
         if (LAY_EN) begin
            b_nxt = '0;
            s_nxt = (s == S_LAST) ? '0 : s + 1'b1;
         end else begin
            b_nxt = b + 1'b1;
         end
      end
      err_set = LAY_EN && (!ADDR_EN || (b != B_LAST));
   end

   // Addresses come from the next counter values so they line up with the counters.
   // Default branch is the s=0 map, which also covers unreachable s >= LAYERS.
   always_comb begin
      bw     = AddrWL'(b_nxt);
      span   = AddrWL'(1);
      p      = '0;
      a_nxt  = bw << 1;
      tw_nxt = '0;
      for (int unsigned k = 1; k < LAYERS; k++) begin
         if (s_nxt == LayWL'(k)) begin
            span   = AddrWL'(1) << k;
            p      = bw & (span - AddrWL'(1));
            a_nxt  = ((bw >> k) << (k + 1)) | p;
            tw_nxt = ButtWL'(p << (LAYERS - 1 - k));
         end
      end
      bb_nxt = a_nxt | span;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         b        <= '0;
         s        <= '0;
         ADDR_A   <= '0;
         ADDR_B   <= AddrWL'(1);
         TW_ADDR  <= '0;
         LAST_BUT <= 1'b0;
         PROT_ERR <= 1'b0;
      end else if (ADDR_RST) begin
         b        <= '0;
         s        <= '0;
         ADDR_A   <= '0;
         ADDR_B   <= AddrWL'(1);
         TW_ADDR  <= '0;
         LAST_BUT <= 1'b0;
         PROT_ERR <= 1'b0;
      end else if (EN) begin
         b        <= b_nxt;
         s        <= s_nxt;
         ADDR_A   <= a_nxt;
         ADDR_B   <= bb_nxt;
         TW_ADDR  <= tw_nxt;
         LAST_BUT <= (b_nxt == B_LAST);
         if (err_set) PROT_ERR <= 1'b1;
      end
   end

   assign LAY_NUM = s;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Scoreboard bench for fft_iter_addr_gen: arithmetic reference model feeds an expectation
// queue that a monitor drains one entry per clock edge.
module tb_fft_iter_addr_gen;

   localparam int LAYERS      = 5;
   localparam int BUTTERFLYES = 16;
   localparam int LayWL       = 3;
   localparam int ButtWL      = 4;
   localparam int AddrWL      = 5;
   localparam int NPTS        = 2 * BUTTERFLYES;

   logic CLK = 1'b0, RST = 1'b0, EN = 1'b0, ADDR_RST = 1'b0, ADDR_EN = 1'b0, LAY_EN = 1'b0;
   logic [AddrWL-1:0] ADDR_A, ADDR_B;
   logic [ButtWL-1:0] TW_ADDR;
   logic [LayWL-1:0]  LAY_NUM;
   logic              LAST_BUT, PROT_ERR;

   fft_iter_addr_gen #(
      .LAYERS(LAYERS), .BUTTERFLYES(BUTTERFLYES), .LayWL(LayWL), .ButtWL(ButtWL), .AddrWL(AddrWL)
   ) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .ADDR_RST(ADDR_RST), .ADDR_EN(ADDR_EN), .LAY_EN(LAY_EN),
      .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .TW_ADDR(TW_ADDR), .LAY_NUM(LAY_NUM),
      .LAST_BUT(LAST_BUT), .PROT_ERR(PROT_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int a; int b; int tw; int lay; int last; int err;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   int mb = 0, ms = 0, merr = 0;
   int seen[LAYERS][NPTS];

   task automatic chk(string name, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic exp_t model_out();
      int span;
      int p;
      exp_t e;
      span   = 1 << ms;
      p      = mb % span;
      e.a    = (mb / span) * 2 * span + p;
      e.b    = e.a + span;
      e.tw   = (p * (1 << (LAYERS - 1 - ms))) % BUTTERFLYES;
      e.lay  = ms;
      e.last = (mb == BUTTERFLYES - 1) ? 1 : 0;
      e.err  = merr;
      return e;
   endfunction

   task automatic model_reset();
      mb = 0; ms = 0; merr = 0;
   endtask

   // One clock of stimulus; returns 2 time units after the edge so outputs are settled.
   task automatic step(input bit en, input bit ae, input bit le, input bit ar);
      @(negedge CLK);
      EN = en; ADDR_EN = ae; LAY_EN = le; ADDR_RST = ar;
      if (ar) model_reset();
      else if (en) begin
         if (le && (!ae || mb != BUTTERFLYES - 1)) merr = 1;
         if (ae) begin
            if (le) begin
               mb = 0;
               ms = (ms + 1) % LAYERS;
            end else begin
               mb = (mb + 1) % BUTTERFLYES;
            end
         end
      end
      q.push_back(model_out());
      @(posedge CLK);
      #2;
   endtask

   task automatic go(input int layer, input int butt);
      step(1, 0, 0, 1);
      for (int l = 0; l < layer; l++) begin
         for (int i = 0; i < BUTTERFLYES - 1; i++) step(1, 1, 0, 0);
         step(1, 1, 1, 0);
      end
      for (int i = 0; i < butt; i++) step(1, 1, 0, 0);
   endtask

   task automatic chk_outs(string tag, int a, int b, int tw);
      chk({tag, "_a"}, int'(ADDR_A), a);
      chk({tag, "_b"}, int'(ADDR_B), b);
      chk({tag, "_tw"}, int'(TW_ADDR), tw);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("mon_addr_a", int'(ADDR_A), e.a);
            chk("mon_addr_b", int'(ADDR_B), e.b);
            chk("mon_tw_addr", int'(TW_ADDR), e.tw);
            chk("mon_lay_num", int'(LAY_NUM), e.lay);
            chk("mon_last_but", int'(LAST_BUT), e.last);
            chk("mon_prot_err", int'(PROT_ERR), e.err);
         end
      end
   end

   initial begin : stim
      int cnt;
      bit en, ae, le, ar;

      #1 RST = 1'b1;
      #1;
      chk_outs("rst0", 0, 1, 0);
      chk("rst0_lay", int'(LAY_NUM), 0);
      chk("rst0_err", int'(PROT_ERR), 0);
      @(negedge CLK);
      RST = 1'b0;
      model_reset();

      go(0, 3);
      chk_outs("l0b3", 6, 7, 0);

      go(1, 3);
      chk_outs("l1b3", 5, 7, 8);
      go(2, 5);
      chk_outs("l2b5", 9, 13, 4);

      go(4, 15);
      chk_outs("l4b15", 15, 31, 15);
      chk("l4b15_last", int'(LAST_BUT), 1);
      step(1, 1, 1, 0);
      chk("wrap_lay", int'(LAY_NUM), 0);
      chk_outs("wrap", 0, 1, 0);
      chk("wrap_last", int'(LAST_BUT), 0);
      chk("wrap_err", int'(PROT_ERR), 0);

      go(0, 7);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      chk_outs("stall", 14, 15, 0);
      step(1, 1, 1, 0);
      chk("err_set", int'(PROT_ERR), 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      chk("err_sticky", int'(PROT_ERR), 1);
      step(0, 0, 0, 1);
      chk("err_clr", int'(PROT_ERR), 0);

      // Asynchronous reset in the middle of a layer, checked before any clock edge.
      go(2, 9);
      @(negedge CLK);
      #1 RST = 1'b1;
      #1;
      chk_outs("rst_mid", 0, 1, 0);
      chk("rst_mid_lay", int'(LAY_NUM), 0);
      chk("rst_mid_err", int'(PROT_ERR), 0);
      #1 RST = 1'b0;
      model_reset();

      go(3, 6);
      step(1, 0, 0, 1);
      chk_outs("addr_rst_mid", 0, 1, 0);

      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 9) != 0);
         ar = ($urandom_range(0, 49) == 0);
         ae = $urandom_range(0, 1);
         if (ae && mb == BUTTERFLYES - 1) le = ($urandom_range(0, 3) != 0);
         else le = ($urandom_range(0, 19) == 0);
         step(en, ae, le, ar);
      end

      // Full 32-point pass: every address must appear exactly once per layer.
      for (int l = 0; l < LAYERS; l++)
         for (int a = 0; a < NPTS; a++) seen[l][a] = 0;
      step(1, 0, 0, 1);
      for (int l = 0; l < LAYERS; l++) begin
         for (int i = 0; i < BUTTERFLYES; i++) begin
            seen[l][int'(ADDR_A)]++;
            seen[l][int'(ADDR_B)]++;
            step(1, 1, (i == BUTTERFLYES - 1), 0);
         end
      end
      for (int l = 0; l < LAYERS; l++) begin
         cnt = 0;
         for (int a = 0; a < NPTS; a++) if (seen[l][a] == 1) cnt++;
         chk($sformatf("cover_layer%0d", l), cnt, NPTS);
      end
      chk("full_run_err", int'(PROT_ERR), 0);

      repeat (3) @(posedge CLK);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
